axi_lite_write_master: RTL and testbench
========================================

Name: axi_lite_write_master

Overview:
- Downstream stage of the DMA read path: captures each word returned from source memory (qualified by the read stage's data_valid) into a small FIFO.
- Drains the FIFO as AXI4-Lite single-beat writes to consecutive destination addresses.
- Reports per-transfer completion, slave error, and FIFO overflow to the top-level DMA controller.

Parameters:
- FIFO_DEPTH, 16, capture FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the transfer word count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; latches dst_addr and num_words; ignored while busy=1.
- dst_addr  input  32  destination byte address; bits [1:0] are ignored and treated as 0.
- num_words  input  CNT_W  number of 32-bit words to write.
- in_valid  input  1  push strobe; driven by the read stage's data_valid.
- in_data  input  32  word pushed into the FIFO when in_valid=1.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set by a push while the FIFO is full.
- m_awaddr  output  32  AXI write address.
- m_awvalid  output  1  AXI write address valid.
- m_awready  input  1  AXI write address ready.
- m_wdata  output  32  AXI write data.
- m_wstrb  output  4  AXI write strobe; constant 4'hF.
- m_wvalid  output  1  AXI write data valid.
- m_wready  input  1  AXI write data ready.
- m_bresp  input  2  AXI write response.
- m_bvalid  input  1  AXI write response valid.
- m_bready  output  1  AXI write response ready.
- busy  output  1  a transfer is in progress.
- done  output  1  one-cycle pulse when the transfer ends.
- error  output  1  sticky; set when any m_bresp != 2'b00 is accepted.

Behaviour:
- Reset (async): all outputs 0 (m_wstrb excepted, fixed 4'hF); FIFO emptied; FSM returns to IDLE.
  - Reset asserted mid-transaction drops AWVALID/WVALID immediately; no AXI stability obligation applies across reset.
- FIFO:
  - Push when in_valid=1 and not full.
  - Push while full drops the word and sets overflow.
  - Pop occurs on the cycle the W handshake completes.
  - Simultaneous push and pop when full is legal: count unchanged, no overflow.
  - Pushes are accepted in every state, including IDLE, so data may arrive before or after start.
- overflow and error clear only on an accepted start (or on reset).
- FSM states: IDLE, ISSUE, RESP, DONE.
  - IDLE: on start, latch addr = {dst_addr[31:2],2'b00}, remaining = num_words, clear error/overflow, set busy. Go to DONE if num_words=0, else ISSUE.
  - ISSUE: while the FIFO is empty, hold AWVALID/WVALID low. Once it is non-empty, assert m_awvalid and m_wvalid together, registered, in the next cycle.
    - m_awaddr = addr; m_wdata = FIFO head.
    - Track aw_done and w_done independently. Each valid deasserts after its own handshake. AW and W may complete in either order or in the same cycle.
    - Once both are done, go to RESP with m_bready=1.
    - Payload stays stable while valid is high and ready is low.
  - RESP: wait for m_bvalid. On handshake:
    - Deassert m_bready.
    - If bresp != 0, set error.
    - addr += 4 (mod 2^32 wrap, no carry out).
    - remaining -= 1.
    - If remaining == 0, go to DONE, else ISSUE.
    - The transfer continues after an error; error is only reported.
  - DONE: pulse done for exactly one cycle, clear busy, return to IDLE.
- Latency, FIFO non-empty and slave always ready: 1 cycle ISSUE setup + 1 cycle handshake + 1 cycle response minimum, i.e. 3 cycles per word. At most one outstanding write.
- Words left in the FIFO after done remain queued for the next transfer.

Test Plan:
- Basic: start, dst_addr=0x1000, num_words=4; push 0xA0..0xA3 back-to-back; slave always ready, BRESP=OKAY -> writes 0xA0..0xA3 to 0x1000/0x1004/0x1008/0x100C in order, one done pulse, error=0, overflow=0.
- AW/W skew: awready delayed 3 cycles, wready immediate (and the reverse) -> exactly one AW and one W handshake per word; awaddr/wdata stable while stalled.
- Overflow: FIFO_DEPTH=16, wready held 0, push 18 words -> fifo_full=1 after 16 pushes, overflow=1, words 17–18 lost; the first 16 are written correctly once the slave is released.
- Error: BRESP=2'b10 on word 2 of 3 -> error=1 sticky, all 3 words still written, done pulses; next start clears error.
- Wrap/unaligned: dst_addr=0xFFFFFFFE, num_words=2 -> writes to 0xFFFFFFFC, then 0x00000000.
- Zero count and reset: num_words=0 -> done on the 2nd cycle after start with no AXI activity. Reset asserted during RESP -> all outputs 0 immediately, FIFO empty, FSM in IDLE.

Source files
------------

// File: rtl/axi_lite_write_master_if.sv
// AXI4-Lite write channel bundle (AW, W, B) between the DMA write master and its slave.
interface axi_lite_write_master_if;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axi_lite_write_master.sv
// DMA write stage: buffers words from the read stage in a FIFO and drains them as
// single-beat AXI4-Lite writes to consecutive word addresses, one write outstanding.
module axi_lite_write_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             fifo_full,
  output logic             overflow,
  axi_lite_write_master_if.master axi,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t           state_reg;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [31:0]      addr_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             issued_reg;
  logic             aw_done_reg;
  logic             w_done_reg;

  logic fifo_empty;
  logic hs_aw;
  logic hs_w;
  logic push;
  logic pop;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign hs_aw      = axi.m_awvalid & axi.m_awready;
  assign hs_w       = axi.m_wvalid & axi.m_wready;
  assign pop        = hs_w;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push       = in_valid & (~fifo_full | pop);

  assign axi.m_wstrb = 4'hF;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      issued_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      axi.m_awaddr  <= '0;
      axi.m_awvalid <= 1'b0;
      axi.m_wdata   <= '0;
      axi.m_wvalid  <= 1'b0;
      axi.m_bready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= dst_addr & 32'hFFFF_FFFC;
            remaining_reg <= num_words;
            error         <= 1'b0;
            overflow      <= 1'b0;
            busy          <= 1'b1;
            issued_reg    <= 1'b0;
            state_reg     <= (num_words == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (!issued_reg) begin
            // The head is captured here and held until W completes; it only moves on pop.
            if (!fifo_empty) begin
              axi.m_awaddr  <= addr_reg;
              axi.m_wdata   <= mem[rd_ptr_reg];
              axi.m_awvalid <= 1'b1;
              axi.m_wvalid  <= 1'b1;
              issued_reg    <= 1'b1;
            end
          end else begin
            if (hs_aw) begin
              axi.m_awvalid <= 1'b0;
              aw_done_reg   <= 1'b1;
            end
            if (hs_w) begin
              axi.m_wvalid <= 1'b0;
              w_done_reg   <= 1'b1;
            end
            if ((aw_done_reg | hs_aw) && (w_done_reg | hs_w)) begin
              axi.m_bready <= 1'b1;
              issued_reg   <= 1'b0;
              aw_done_reg  <= 1'b0;
              w_done_reg   <= 1'b0;
              state_reg    <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.m_bvalid) begin
            axi.m_bready  <= 1'b0;
            if (axi.m_bresp != 2'b00) error <= 1'b1;
            addr_reg      <= addr_reg + 32'd4;
            remaining_reg <= remaining_reg - CNT_W'(1);
            state_reg     <= (remaining_reg == CNT_W'(1)) ? DONE : ISSUE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // Placed last so a drop in the same cycle as an accepted start is still reported.
      if (in_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Directed bench for axi_lite_write_master: a negedge slave/monitor checks every AXI
// handshake against expected address/data queues filled by the stimulus process.
module tb_axi_lite_write_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        fifo_full, overflow, busy, done, error;

  axi_lite_write_master_if axi_bus ();

  axi_lite_write_master #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .fifo_full(fifo_full), .overflow(overflow),
    .axi(axi_bus), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int aw_delay = 0, w_delay = 0, b_delay = 0, err_at = -1;
  bit w_hold = 1'b0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Slave + monitor: readies are decided at the negedge and held through the next posedge,
  // so valid&ready seen here is exactly the handshake the DUT will take.
  bit          aw_got, w_got, b_pending, aw_stall, w_stall, done_prev;
  int          aw_wait, w_wait, b_wait;
  logic [31:0] aw_prev, w_prev;
  always @(negedge clk) begin
    if (rst) begin
      axi_bus.m_awready = 1'b0; axi_bus.m_wready = 1'b0;
      axi_bus.m_bvalid = 1'b0;  axi_bus.m_bresp = 2'b00;
      aw_got = 0; w_got = 0; b_pending = 0; aw_stall = 0; w_stall = 0; done_prev = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
    end else begin
      if (done) begin
        done_cnt++;
        if (done_prev) chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
      end
      done_prev = done;

      if (aw_got && w_got) begin
        b_pending = 1; b_wait = 0; aw_got = 0; w_got = 0;
      end
      if (b_pending && b_wait >= b_delay) begin
        axi_bus.m_bvalid = 1'b1;
        axi_bus.m_bresp  = (b_hs_cnt == err_at) ? 2'b10 : 2'b00;
        if (axi_bus.m_bready) begin
          b_hs_cnt++;
          b_pending = 0;
        end
      end else begin
        axi_bus.m_bvalid = 1'b0;
        if (b_pending) b_wait++;
      end

      if (axi_bus.m_awvalid) begin
        if (aw_stall) chk("awaddr_stable", axi_bus.m_awaddr, aw_prev);
        axi_bus.m_awready = (aw_wait >= aw_delay);
        if (axi_bus.m_awready) begin
          aw_wait = 0; aw_stall = 0; aw_hs_cnt++; aw_got = 1;
          if (exp_addr_q.size() == 0) chk("aw_unexpected", axi_bus.m_awaddr, 32'hDEAD_0000);
          else chk("awaddr", axi_bus.m_awaddr, exp_addr_q.pop_front());
        end else begin
          aw_wait++; aw_stall = 1; aw_prev = axi_bus.m_awaddr;
        end
      end else begin
        axi_bus.m_awready = 1'b0; aw_stall = 0;
      end

      if (axi_bus.m_wvalid) begin
        if (w_stall) chk("wdata_stable", axi_bus.m_wdata, w_prev);
        axi_bus.m_wready = !w_hold && (w_wait >= w_delay);
        if (axi_bus.m_wready) begin
          w_wait = 0; w_stall = 0; w_hs_cnt++; w_got = 1;
          chk("wstrb", {28'd0, axi_bus.m_wstrb}, 32'hF);
          if (exp_data_q.size() == 0) chk("w_unexpected", axi_bus.m_wdata, 32'hDEAD_0001);
          else chk("wdata", axi_bus.m_wdata, exp_data_q.pop_front());
        end else begin
          if (!w_hold) w_wait++;
          w_stall = 1; w_prev = axi_bus.m_wdata;
        end
      end else begin
        axi_bus.m_wready = 1'b0; w_stall = 0;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    dst_addr = a; num_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n, input int keep);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = base + i;
      if (i < keep) exp_data_q.push_back(base + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_addrs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_done(input string name, input int base, input int limit);
    int i = 0;
    while (done_cnt == base && i < limit) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_count"}, done_cnt, base + 1);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({name, "_addr_q_empty"}, exp_addr_q.size(), 32'd0);
    chk({name, "_data_q_empty"}, exp_data_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, aw0, w0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_awvalid", {31'd0, axi_bus.m_awvalid}, 0);
    chk("rst_wvalid", {31'd0, axi_bus.m_wvalid}, 0);
    chk("rst_bready", {31'd0, axi_bus.m_bready}, 0);
    chk("rst_fifo_full", {31'd0, fifo_full}, 0);
    chk("rst_wstrb", {28'd0, axi_bus.m_wstrb}, 32'hF);
    rst = 1'b0;

    // Basic: four words to 0x1000..0x100C
    d0 = done_cnt; aw0 = aw_hs_cnt;
    expect_addrs(32'h1000, 4);
    start_xfer(32'h1000, 16'd4);
    chk("basic_busy", {31'd0, busy}, 1);
    push_words(32'hA0, 4, 4);
    wait_done("basic", d0, 200);
    chk("basic_aw_count", aw_hs_cnt - aw0, 4);
    chk("basic_error", {31'd0, error}, 0);
    chk("basic_overflow", {31'd0, overflow}, 0);

    // AW stalled 3 cycles, W immediate; then the reverse
    aw_delay = 3; w_delay = 0;
    d0 = done_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    expect_addrs(32'h2000, 2);
    start_xfer(32'h2000, 16'd2);
    push_words(32'hB0, 2, 2);
    wait_done("skew_aw", d0, 200);
    chk("skew_aw_aw_count", aw_hs_cnt - aw0, 2);
    chk("skew_aw_w_count", w_hs_cnt - w0, 2);
    aw_delay = 0; w_delay = 3;
    d0 = done_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    expect_addrs(32'h2100, 2);
    start_xfer(32'h2100, 16'd2);
    push_words(32'hC0, 2, 2);
    wait_done("skew_w", d0, 200);
    chk("skew_w_aw_count", aw_hs_cnt - aw0, 2);
    chk("skew_w_w_count", w_hs_cnt - w0, 2);
    w_delay = 0;

    // Overflow: W held off, 18 pushes, last two dropped
    w_hold = 1'b1;
    d0 = done_cnt;
    expect_addrs(32'h3000, 16);
    start_xfer(32'h3000, 16'd16);
    push_words(32'h300, 16, 16);
    chk("ovf_full_at_16", {31'd0, fifo_full}, 1);
    chk("ovf_not_yet", {31'd0, overflow}, 0);
    push_words(32'h310, 2, 0);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_still_full", {31'd0, fifo_full}, 1);
    w_hold = 1'b0;
    wait_done("ovf", d0, 500);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    chk("ovf_fifo_drained", {31'd0, fifo_full}, 0);

    // Error on second of three responses
    d0 = done_cnt; w0 = w_hs_cnt;
    err_at = b_hs_cnt + 1;
    expect_addrs(32'h4000, 3);
    start_xfer(32'h4000, 16'd3);
    chk("err_start_clears_ovf", {31'd0, overflow}, 0);
    push_words(32'hE0, 3, 3);
    wait_done("err", d0, 200);
    chk("err_words", w_hs_cnt - w0, 3);
    chk("err_sticky", {31'd0, error}, 1);
    err_at = -1;

    // Unaligned start address wraps past 2^32
    d0 = done_cnt;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    start_xfer(32'hFFFF_FFFE, 16'd2);
    chk("wrap_start_clears_err", {31'd0, error}, 0);
    push_words(32'hF0, 2, 2);
    wait_done("wrap", d0, 200);

    // Zero count: done on the second cycle after start, no AXI traffic
    aw0 = aw_hs_cnt; d0 = done_cnt;
    start_xfer(32'h5000, 16'd0);
    chk("zero_done_early", {31'd0, done}, 0);
    chk("zero_busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("zero_done_pulse", {31'd0, done}, 1);
    chk("zero_busy_clear", {31'd0, busy}, 0);
    @(negedge clk);
    chk("zero_no_aw", aw_hs_cnt - aw0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    // Reset while waiting for B; second pushed word must be discarded
    b_delay = 20;
    expect_addrs(32'h6000, 1);
    start_xfer(32'h6000, 16'd1);
    push_words(32'h600, 2, 1);
    for (int i = 0; i < 50 && !axi_bus.m_bready; i++) @(negedge clk);
    chk("rst_mid_in_resp", {31'd0, axi_bus.m_bready}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_bready", {31'd0, axi_bus.m_bready}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_awvalid", {31'd0, axi_bus.m_awvalid}, 0);
    chk("rst_mid_wvalid", {31'd0, axi_bus.m_wvalid}, 0);
    chk("rst_mid_error", {31'd0, error}, 0);
    @(negedge clk);
    rst = 1'b0; b_delay = 0;
    d0 = done_cnt;
    expect_addrs(32'h7000, 1);
    start_xfer(32'h7000, 16'd1);
    repeat (5) @(negedge clk);
    chk("rst_fifo_emptied", {31'd0, axi_bus.m_awvalid}, 0);
    push_words(32'hBEEF, 1, 1);
    wait_done("post_rst", d0, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
